// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset defaults,
// reset polarity and the fetch FSM encoding.
package fetch_unit_pkg;

  localparam int OPERAND_WIDTH = 32;

  localparam logic [OPERAND_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Reset is synchronous and active-low across the fetch stage.
  localparam logic RST_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush. Used for the instruction buffer and for
// the queue of PCs whose responses are still in flight.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst == RST_ACTIVE)
    !(push && full && !pop && !flush));
  no_underflow: assert property (@(posedge clk) disable iff (rst == RST_ACTIVE)
    !(pop && empty && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues credit-limited requests to
// instruction memory, buffers in-order responses and presents them to decode.
//
// Handshakes: the memory request is a valid/ready pair (o_imem_req/i_imem_gnt);
// once o_imem_req is high, it and o_imem_addr stay unchanged until the cycle
// i_imem_gnt is seen, and only a redirect or reset may withdraw it. The output
// side pops the head on any cycle with o_valid=1 and i_stall=0; while stalled
// the head is held.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN       = OPERAND_WIDTH,
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instruction,
  output logic [XLEN-1:0] o_pc,
  output logic [1:0]      o_dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t      state, state_next;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   redirect_target;
  logic [CW-1:0]     outstanding, outstanding_next;
  logic [CW-1:0]     drop_cnt, drop_cnt_next;
  logic [CW:0]       inflight_total;
  logic              req_fire;
  logic              resp_keep;
  logic              buf_pop;
  logic [2*XLEN-1:0] buf_head;
  logic              buf_full, buf_empty;
  logic [CW-1:0]     buf_count;
  logic [XLEN-1:0]   pcq_head;
  logic              pcq_full, pcq_empty;
  logic [CW-1:0]     pcq_count;

  assign redirect_target = i_redirect_pc & ~XLEN'(3);
  assign inflight_total  = {1'b0, outstanding} + {1'b0, buf_count};

  // Credit: never have more requests outstanding than the buffer could absorb.
  assign o_imem_req  = (state == FETCH) && !i_redirect &&
                       (inflight_total < (CW+1)'(FIFO_DEPTH));
  assign o_imem_addr = pc;
  assign req_fire    = o_imem_req && i_imem_gnt;

  // A response is kept only when no stale responses remain to be discarded.
  assign resp_keep = i_imem_rvalid && !i_redirect && (drop_cnt == '0) && !pcq_empty;
  assign buf_pop   = o_valid && !i_stall && !i_redirect;

  assign o_valid       = !buf_empty;
  assign o_pc          = o_valid ? buf_head[2*XLEN-1:XLEN] : pc;
  assign o_instruction = o_valid ? buf_head[XLEN-1:0] : '0;
  assign o_dbg_state   = state;

  // Counter updates and FSM transitions; redirect overrides everything else.
  always_comb begin
    outstanding_next = outstanding;
    if (req_fire) outstanding_next = outstanding_next + CW'(1);
    if (i_imem_rvalid && outstanding != '0) outstanding_next = outstanding_next - CW'(1);

    drop_cnt_next = drop_cnt;
    if (i_redirect) drop_cnt_next = outstanding_next;
    else if (i_imem_rvalid && drop_cnt != '0) drop_cnt_next = drop_cnt - CW'(1);

    state_next = state;
    case (state)
      BOOT:    state_next = FETCH;
      FETCH:   if (i_redirect && outstanding_next != '0) state_next = DRAIN;
      DRAIN:   if (!i_redirect && drop_cnt_next == '0) state_next = FETCH;
      default: state_next = BOOT;
    endcase
  end

  // State, PC and counter registers.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
      if (i_redirect)    pc <= redirect_target;
      else if (req_fire) pc <= pc + XLEN'(4);
    end
  end

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_instr_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (resp_keep),
    .pop   (buf_pop),
    .flush (i_redirect),
    .wdata ({pcq_head, i_imem_rdata}),
    .rdata (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (resp_keep),
    .flush (i_redirect),
    .wdata (pc),
    .rdata (pcq_head),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_count)
  );

  credit_no_overflow: assert property (@(posedge clk) disable iff (rst == RST_ACTIVE)
    !(resp_keep && buf_full && !buf_pop));
  pcq_no_overflow: assert property (@(posedge clk) disable iff (rst == RST_ACTIVE)
    !(req_fire && pcq_full));
  pcq_tracks_live: assert property (@(posedge clk) disable iff (rst == RST_ACTIVE)
    pcq_count == CW'(outstanding - drop_cnt));
  outstanding_bound: assert property (@(posedge clk) disable iff (rst == RST_ACTIVE)
    outstanding <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural memory and a PC-sequence
// model of what decode must receive.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model controls and state
  int          gnt_en = 1;
  int          lat    = 1;
  int          mstep  = 0;
  logic [31:0] req_q[$];
  int          due_q[$];

  // output model
  logic [31:0] exp_pc = 32'h0;
  logic        rst_seen = 1'b0;
  logic        hold_prev = 1'b0;
  logic        req_prev = 1'b0;
  logic [31:0] held_addr = 32'h0;
  int          accept_total = 0;
  int          base;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_valid       (o_valid),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .o_dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // in-order instruction memory: grant per gnt_en, answer lat cycles later
  initial begin
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      mstep++;
      if (!rst) begin
        req_q.delete();
        due_q.delete();
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
      end else begin
        if (req_q.size() != 0 && due_q[0] <= mstep) begin
          i_imem_rvalid = 1'b1;
          i_imem_rdata  = mem_word(req_q[0]);
          void'(req_q.pop_front());
          void'(due_q.pop_front());
        end else begin
          i_imem_rvalid = 1'b0;
          i_imem_rdata  = 32'h0;
        end
        i_imem_gnt = (gnt_en != 0);
        if (gnt_en != 0 && o_imem_req) begin
          req_q.push_back(o_imem_addr);
          due_q.push_back(mstep + lat);
        end
      end
    end
  end

  // scoreboard: every valid head must be the next PC of the sequential/redirect stream
  always @(negedge clk) begin
    if (!rst) begin
      exp_pc    = 32'h0;
      rst_seen  = 1'b1;
      hold_prev = 1'b0;
      req_prev  = 1'b0;
    end else begin
      if (rst_seen) begin
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_req", {31'b0, o_imem_req}, 32'd0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_instr", o_instruction, 32'h0);
        rst_seen = 1'b0;
      end
      if (hold_prev) check("stall_hold_valid", {31'b0, o_valid}, 32'd1);
      if (req_prev) begin
        check("req_held", {31'b0, o_imem_req | i_redirect}, 32'd1);
        if (!i_redirect) check("addr_held", o_imem_addr, held_addr);
      end
      if (o_valid) begin
        check("model_pc", o_pc, exp_pc);
        check("model_instr", o_instruction, mem_word(exp_pc));
      end
      if (o_valid && !i_stall && !i_redirect) begin
        exp_pc = exp_pc + 32'd4;
        accept_total++;
      end
      if (i_redirect) exp_pc = i_redirect_pc & ~32'h3;
      hold_prev = o_valid && i_stall && !i_redirect;
      req_prev  = o_imem_req && !i_imem_gnt && !i_redirect;
      held_addr = o_imem_addr;
      check("outstanding_le_depth", {31'b0, req_q.size() <= 2}, 32'd1);
    end
  end

  initial begin
    rst = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;

    // 1: reset release, streaming memory
    gnt_en = 1; lat = 1;
    do_reset();
    probe(); check("t1_boot_req", {31'b0, o_imem_req}, 32'd0);
    check("t1_boot_state", {30'b0, dbg_state}, {30'b0, fetch_unit_pkg::BOOT});
    step(); probe(); check("t1_req0", {31'b0, o_imem_req}, 32'd1); check("t1_addr0", o_imem_addr, 32'h0);
    step(); probe(); check("t1_addr4", o_imem_addr, 32'h4); check("t1_novalid", {31'b0, o_valid}, 32'd0);
    step(); probe(); check("t1_valid", {31'b0, o_valid}, 32'd1); check("t1_pc", o_pc, 32'h0);
    check("t1_instr", o_instruction, mem_word(32'h0));
    repeat (12) step();

    // 2: stall from release; buffer fills, request drops, then resume
    i_stall = 1'b1;
    do_reset();
    repeat (4) step();
    probe(); check("t2_full_valid", {31'b0, o_valid}, 32'd1); check("t2_full_req", {31'b0, o_imem_req}, 32'd0);
    check("t2_head_pc", o_pc, 32'h0);
    step(); probe(); check("t2_hold_pc", o_pc, 32'h0); check("t2_hold_req", {31'b0, o_imem_req}, 32'd0);
    step(); i_stall = 1'b0;
    repeat (12) step();

    // 3: two outstanding at 0x10/0x14, redirect to 0x103
    lat = 3;
    do_reset();
    i_redirect = 1'b1; i_redirect_pc = 32'h10;
    step(); i_redirect = 1'b0;
    probe(); check("t3_addr10", o_imem_addr, 32'h10); check("t3_req10", {31'b0, o_imem_req}, 32'd1);
    step(); probe(); check("t3_addr14", o_imem_addr, 32'h14);
    step(); i_redirect = 1'b1; i_redirect_pc = 32'h103;
    probe(); check("t3_redir_req", {31'b0, o_imem_req}, 32'd0);
    step(); i_redirect = 1'b0;
    probe(); check("t3_drain_req", {31'b0, o_imem_req}, 32'd0);
    check("t3_drain_state", {30'b0, dbg_state}, {30'b0, fetch_unit_pkg::DRAIN});
    step(); probe(); check("t3_drain_req2", {31'b0, o_imem_req}, 32'd0);
    step(); probe(); check("t3_new_req", {31'b0, o_imem_req}, 32'd1); check("t3_new_addr", o_imem_addr, 32'h100);
    check("t3_fetch_state", {30'b0, dbg_state}, {30'b0, fetch_unit_pkg::FETCH});
    repeat (4) step();
    probe(); check("t3_first_valid", {31'b0, o_valid}, 32'd1); check("t3_first_pc", o_pc, 32'h100);
    repeat (10) step();

    // 4: redirect in the same cycle as a response, two outstanding
    lat = 2;
    do_reset();
    step(); step(); step();
    i_redirect = 1'b1; i_redirect_pc = 32'h40;
    probe(); check("t4_rv_same", {31'b0, i_imem_rvalid}, 32'd1);
    step(); i_redirect = 1'b0;
    probe(); check("t4_req_off", {31'b0, o_imem_req}, 32'd0); check("t4_valid_off", {31'b0, o_valid}, 32'd0);
    step(); probe(); check("t4_req40", {31'b0, o_imem_req}, 32'd1); check("t4_addr40", o_imem_addr, 32'h40);
    step(); step(); step();
    probe(); check("t4_first_valid", {31'b0, o_valid}, 32'd1); check("t4_first_pc", o_pc, 32'h40);
    repeat (10) step();

    // 5: grant withheld for four cycles
    lat = 1; gnt_en = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(); probe();
      check("t5_req_held", {31'b0, o_imem_req}, 32'd1);
      check("t5_addr_held", o_imem_addr, 32'h0);
    end
    step(); gnt_en = 1;
    probe(); check("t5_gnt_addr", o_imem_addr, 32'h0);
    step(); probe(); check("t5_next_addr", o_imem_addr, 32'h4);
    repeat (10) step();

    // 6: reset with the buffer full
    i_stall = 1'b1;
    do_reset();
    repeat (5) step();
    probe(); check("t6_full_valid", {31'b0, o_valid}, 32'd1);
    step(); rst = 1'b0;
    step(); rst = 1'b1; i_stall = 1'b0;
    probe(); check("t6_valid0", {31'b0, o_valid}, 32'd0); check("t6_req0", {31'b0, o_imem_req}, 32'd0);
    check("t6_pc_reset", o_pc, 32'h0);
    step(); probe(); check("t6_restart_req", {31'b0, o_imem_req}, 32'd1); check("t6_restart_addr", o_imem_addr, 32'h0);
    repeat (10) step();

    // mixed stalls, grant gaps, latencies and redirects
    for (int k = 0; k < 300; k++) begin
      step();
      i_stall       = ($urandom_range(0, 3) == 0);
      gnt_en        = ($urandom_range(0, 4) != 0) ? 1 : 0;
      lat           = $urandom_range(1, 3);
      i_redirect    = ($urandom_range(0, 19) == 0);
      i_redirect_pc = $urandom;
    end
    step();
    i_stall = 1'b0; i_redirect = 1'b0; gnt_en = 1; lat = 1;
    repeat (10) step();
    base = accept_total;
    repeat (21) step();
    probe();
    check("steady_throughput", {31'b0, (accept_total - base) >= 10}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
